// File: rtl/da_bitplane_accumulator.sv
// da_bitplane_accumulator: receive end of a bit-serial distributed-arithmetic FIR.
// Optional build macro DA_OUT_SATURATE_EN: saturate y instead of wrapping it.
module da_bitplane_accumulator #(
  parameter int COEF_W    = 16,
  parameter int SAMPLE_W  = 16,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               A0,
  input  logic [7:0]               A1,
  input  logic [7:0]               A2,
  input  logic [7:0]               A3,
  input  logic [7:0]               A4,
  input  logic [7:0]               A5,
  input  logic [7:0]               A6,
  input  logic [7:0]               A7,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic [OUT_W-1:0]         y,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     coef_rej
);

  localparam int P_W   = COEF_W + 6;
  localparam int ACC_W = P_W + SAMPLE_W;
  localparam int CNT_W = $clog2(SAMPLE_W) + 1;
  localparam int EXT_W = ACC_W + OUT_W + OUT_SHIFT;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state, state_next;
  logic signed [COEF_W-1:0]  coef [64];
  logic signed [ACC_W-1:0]   acc, acc_next, base, p_ext, term;
  logic signed [P_W-1:0]     psum;
  logic [CNT_W-1:0]          count, count_next, k;
  logic [63:0]               taps;
  logic                      start, accept, last, coef_ok;

  // Handshake: in_valid marks one plane per cycle with no back-pressure; every
  // valid plane is consumed in ACCUM, while IDLE consumes only a plane with in_first.
  assign taps    = {A7, A6, A5, A4, A3, A2, A1, A0};
  assign start   = in_valid && in_first;
  assign accept  = in_valid && (in_first || (state == ACCUM));
  assign k       = in_first ? '0 : count;
  assign last    = accept && (k == CNT_W'(SAMPLE_W - 1));
  assign coef_ok = coef_we && (state == IDLE) && !start;
  assign busy    = (state == ACCUM);

  function automatic logic [OUT_W-1:0] out_map(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] w;
    logic [OUT_W-1:0]        r;
`ifdef DA_OUT_SATURATE_EN
    logic                    ovf;
`endif
    w = {{(EXT_W-ACC_W){v[ACC_W-1]}}, v};
    w = w >>> OUT_SHIFT;
    r = w[OUT_W-1:0];
`ifdef DA_OUT_SATURATE_EN
    // Any bit above the output sign that disagrees with the true sign is overflow.
    ovf = 1'b0;
    for (int i = OUT_W - 1; i < EXT_W; i++) begin
      if (w[i] != w[EXT_W-1]) ovf = 1'b1;
    end
    if (ovf) r = w[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
    return r;
  endfunction

  always_comb begin
    psum = '0;
    for (int t = 0; t < 64; t++) begin
      if (taps[t]) psum = psum + {{6{coef[t][COEF_W-1]}}, coef[t]};
    end
  end

  // The sign plane carries negative weight in two's complement, hence the subtract.
  always_comb begin
    p_ext      = {{SAMPLE_W{psum[P_W-1]}}, psum};
    term       = p_ext <<< k;
    base       = in_first ? '0 : acc;
    acc_next   = (k == CNT_W'(SAMPLE_W - 1)) ? base - term : base + term;
    count_next = last ? '0 : k + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !last) state_next = ACCUM;
      ACCUM:   if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= '0;
      count     <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      frame_err <= 1'b0;
      coef_rej  <= 1'b0;
      for (int t = 0; t < 64; t++) coef[t] <= '0;
    end else begin
      y_valid   <= last;
      frame_err <= (state == ACCUM) && start;
      coef_rej  <= coef_we && !coef_ok;
      if (accept) begin
        acc   <= acc_next;
        count <= count_next;
      end
      if (last)    y <= out_map(acc_next);
      if (coef_ok) coef[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_da_bitplane_accumulator.sv
// Bench for da_bitplane_accumulator: a direct-convolution model feeds an expected-y
// queue; a second instance with OUT_W=16 covers the narrow-output wrap/saturate case.
module tb_da_bitplane_accumulator;

  logic              clk = 1'b0;
  logic              resetn;
  logic [7:0]        a [8];
  logic              in_valid, in_first, coef_we;
  logic [5:0]        coef_addr;
  logic signed [15:0] coef_data;
  logic [31:0]       y;
  logic [15:0]       y16;
  logic              y_valid, busy, frame_err, coef_rej;
  logic              y_valid16, busy16, frame_err16, coef_rej16;

  logic [15:0]        tap [64];
  logic signed [15:0] coef_m [64];
  logic [31:0]        exp_q[$];
  logic [15:0]        exp16_q[$];
  logic               pend_y, pend_err, pend_rej;
  int                 n_checks = 0;
  int                 n_pass = 0;

  always #5 clk = ~clk;

  da_bitplane_accumulator #(.OUT_W(32)) u_dut (
    .clk(clk), .resetn(resetn),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .in_valid(in_valid), .in_first(in_first), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .y(y), .y_valid(y_valid), .busy(busy), .frame_err(frame_err),
    .coef_rej(coef_rej)
  );

  da_bitplane_accumulator #(.OUT_W(16)) u_dut16 (
    .clk(clk), .resetn(resetn),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .in_valid(in_valid), .in_first(in_first), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .y(y16), .y_valid(y_valid16), .busy(busy16), .frame_err(frame_err16),
    .coef_rej(coef_rej16)
  );

  function automatic longint dot();
    longint s = 0;
    for (int t = 0; t < 64; t++) s += longint'(coef_m[t]) * longint'($signed(tap[t]));
    return s;
  endfunction

  function automatic logic [31:0] map32(input longint v);
    logic [31:0] r;
    r = v[31:0];
`ifdef DA_OUT_SATURATE_EN
    if (v > 64'sd2147483647) r = 32'h7fffffff;
    else if (v < -64'sd2147483648) r = 32'h80000000;
`endif
    return r;
  endfunction

  function automatic logic [15:0] map16(input longint v);
    logic [15:0] r;
    r = v[15:0];
`ifdef DA_OUT_SATURATE_EN
    if (v > 64'sd32767) r = 16'h7fff;
    else if (v < -64'sd32768) r = 16'h8000;
`endif
    return r;
  endfunction

  // One cycle: check what the previous edge produced, then drive the next inputs.
  task automatic tick(input logic v, input logic f, input int k,
                      input logic we, input logic [5:0] addr, input logic [15:0] data);
    logic [31:0] e32;
    logic [15:0] e16;
    @(negedge clk);
    if (pend_y) begin
      e32 = exp_q.pop_front();
      e16 = exp16_q.pop_front();
      n_checks++;
      if (y_valid !== 1'b1 || y_valid16 !== 1'b1)
        $display("FAIL y_valid_pulse: got %b/%b want 1/1", y_valid, y_valid16);
      else n_pass++;
      n_checks++;
      if (y !== e32) $display("FAIL y32: got %h want %h", y, e32);
      else n_pass++;
      n_checks++;
      if (y16 !== e16) $display("FAIL y16: got %h want %h", y16, e16);
      else n_pass++;
    end else begin
      n_checks++;
      if (y_valid !== 1'b0 || y_valid16 !== 1'b0)
        $display("FAIL y_valid_idle: got %b/%b want 0/0", y_valid, y_valid16);
      else n_pass++;
    end
    n_checks++;
    if (frame_err !== pend_err || frame_err16 !== pend_err)
      $display("FAIL frame_err: got %b/%b want %b", frame_err, frame_err16, pend_err);
    else n_pass++;
    n_checks++;
    if (coef_rej !== pend_rej || coef_rej16 !== pend_rej)
      $display("FAIL coef_rej: got %b/%b want %b", coef_rej, coef_rej16, pend_rej);
    else n_pass++;
    pend_y = 1'b0; pend_err = 1'b0; pend_rej = 1'b0;
    for (int g = 0; g < 8; g++)
      for (int b = 0; b < 8; b++) a[g][b] = tap[8*g+b][k];
    in_valid = v; in_first = f;
    coef_we = we; coef_addr = addr; coef_data = data;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 0, 1'b0, 6'd0, 16'd0);
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic [15:0] data, input logic rej);
    tick(1'b0, 1'b0, 0, 1'b1, addr, data);
    if (!rej) coef_m[addr] = data;
    pend_rej = rej;
  endtask

  task automatic push_expected();
    exp_q.push_back(map32(dot()));
    exp16_q.push_back(map16(dot()));
    pend_y = 1'b1;
  endtask

  task automatic check_busy(input logic want, input string name);
    n_checks++;
    if (busy !== want || busy16 !== want)
      $display("FAIL %s: got %b/%b want %b", name, busy, busy16, want);
    else n_pass++;
  endtask

  task automatic run_frame(input int stall, input bit tail);
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, k == 0, k, 1'b0, 6'd0, 16'd0);
      if (k == 1) check_busy(1'b1, "busy_in_frame");
      if (k == 15) push_expected();
      else repeat (stall) idle();
    end
    if (tail) begin
      idle();
      check_busy(1'b0, "busy_after_frame");
    end
  endtask

  task automatic clear_taps();
    for (int t = 0; t < 64; t++) tap[t] = 16'd0;
  endtask

  task automatic random_taps();
    for (int t = 0; t < 64; t++) tap[t] = 16'($urandom_range(0, 65535));
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b0; in_first = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    for (int g = 0; g < 8; g++) a[g] = '0;
    for (int t = 0; t < 64; t++) coef_m[t] = '0;
    pend_y = 1'b0; pend_err = 1'b0; pend_rej = 1'b0;
    clear_taps();
    repeat (3) @(negedge clk);
    n_checks++;
    if (y !== 32'd0 || y16 !== 16'd0) $display("FAIL reset_y: got %h/%h want 0", y, y16);
    else n_pass++;
    n_checks++;
    if ({y_valid, frame_err, coef_rej} !== 3'b000)
      $display("FAIL reset_pulses: got %b want 000", {y_valid, frame_err, coef_rej});
    else n_pass++;
    check_busy(1'b0, "reset_busy");
    resetn = 1'b1;
    idle();
  endtask

  task automatic test_single_tap();
    write_coef(6'd0, 16'd1, 1'b0);
    clear_taps();
    tap[0] = 16'h0005;
    run_frame(0, 1'b1);
  endtask

  task automatic test_sign_plane();
    write_coef(6'd0, 16'd3, 1'b0);
    clear_taps();
    tap[0] = 16'hFFFF;
    run_frame(0, 1'b1);
  endtask

  task automatic test_all_taps_and_stall();
    for (int t = 0; t < 64; t++) write_coef(6'(t), 16'(t + 1), 1'b0);
    for (int t = 0; t < 64; t++) tap[t] = 16'h0001;
    run_frame(0, 1'b1);
    run_frame(4, 1'b1);
  endtask

  task automatic test_extreme();
    for (int t = 0; t < 64; t++) write_coef(6'(t), 16'h7FFF, 1'b0);
    for (int t = 0; t < 64; t++) tap[t] = 16'h8000;
    run_frame(1, 1'b1);
  endtask

  task automatic test_frame_err();
    random_taps();
    for (int k = 0; k < 7; k++) tick(1'b1, k == 0, k, 1'b0, 6'd0, 16'd0);
    random_taps();
    tick(1'b1, 1'b1, 0, 1'b0, 6'd0, 16'd0);
    pend_err = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick(1'b1, 1'b0, k, 1'b0, 6'd0, 16'd0);
      if (k == 1) check_busy(1'b1, "busy_after_restart");
      if (k == 15) push_expected();
    end
    idle();
  endtask

  task automatic test_coef_rej();
    random_taps();
    for (int k = 0; k < 4; k++) tick(1'b1, k == 0, k, 1'b0, 6'd0, 16'd0);
    write_coef(6'd5, 16'h1234, 1'b1);
    for (int k = 4; k < 16; k++) begin
      tick(1'b1, 1'b0, k, 1'b0, 6'd0, 16'd0);
      if (k == 15) push_expected();
    end
    idle();
    // A write in the same cycle as a frame start is also dropped.
    random_taps();
    tick(1'b1, 1'b1, 0, 1'b1, 6'd9, 16'h4321);
    pend_rej = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick(1'b1, 1'b0, k, 1'b0, 6'd0, 16'd0);
      if (k == 15) push_expected();
    end
    idle();
  endtask

  task automatic test_reset_mid_frame();
    random_taps();
    for (int k = 0; k < 10; k++) tick(1'b1, k == 0, k, 1'b0, 6'd0, 16'd0);
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (y !== 32'd0 || y16 !== 16'd0) $display("FAIL midreset_y: got %h/%h want 0", y, y16);
    else n_pass++;
    check_busy(1'b0, "midreset_busy");
    for (int t = 0; t < 64; t++) coef_m[t] = '0;
    idle();
    idle();
    resetn = 1'b1;
    repeat (3) idle();
    for (int i = 0; i < 8; i++)
      write_coef(6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)), 1'b0);
    random_taps();
    run_frame(0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      random_taps();
      run_frame($urandom_range(0, 1), f == 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_tap();
    test_sign_plane();
    test_all_taps_and_stall();
    test_extreme();
    test_frame_err();
    test_coef_rej();
    test_reset_mid_frame();
    test_back_to_back();
    idle();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL leftover_expected: got %0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
